spectrum_frame_packer: RTL and testbench

Packs one CCD line readout into a framed byte stream for the UART transmitter. Sits between the CCD/ADC sampling path, which delivers 16-bit pixel words paced by the CCD clocks, and the UART_TX byte handshake. It buffers pixels in a small FIFO, adds a header, frame counter, length, status and checksum, and emits bytes under valid/ready flow control.

---
 rtl/spectrum_frame_packer.sv | 223 ++++++++++++++++++++++
 tb/tb_spectrum_frame_packer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_frame_packer.sv
// Buffers one CCD line of 16-bit pixels and emits it as a framed byte packet
// (header, frame count, length, payload, status, checksum) under valid/ready.
module spectrum_frame_packer #(
    parameter int unsigned PIXELS     = 3694,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pixel_valid,
    input  logic [15:0] pixel_data,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = FIFO_DEPTH[CW-1:0];
    localparam logic [15:0]   Len     = PIXELS[15:0];
    localparam logic [15:0]   LastIdx = Len - 16'd1;

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StHdr0   = 4'd1;
    localparam logic [3:0] StHdr1   = 4'd2;
    localparam logic [3:0] StFcnt   = 4'd3;
    localparam logic [3:0] StLenH   = 4'd4;
    localparam logic [3:0] StLenL   = 4'd5;
    localparam logic [3:0] StPixH   = 4'd6;
    localparam logic [3:0] StPixL   = 4'd7;
    localparam logic [3:0] StStatus = 4'd8;
    localparam logic [3:0] StCsum   = 4'd9;

    logic [3:0]    state_q, state_d;
    logic [7:0]    tx_data_q, data_d;
    logic          tx_valid_q, valid_d;
    logic [15:0]   hold_q, hold_d;
    logic [15:0]   pix_cnt_q, pix_cnt_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic [7:0]    csum_q, csum_d;
    logic          capturing_q, capturing_d;
    logic [15:0]   cap_cnt_q, cap_cnt_d;
    logic          drop_frame_q, drop_frame_d;
    logic          overflow_q;

    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          fifo_full, fifo_empty;
    logic          start_accept, cap_active, beat, push, pop, load_pix, xfer;

    assign fifo_full    = (count_q == FullCnt);
    assign fifo_empty   = (count_q == '0);
    assign xfer         = tx_valid_q && tx_data_ready;
    assign start_accept = frame_start && (state_q == StIdle);
    // A pixel arriving together with the accepted start belongs to the new frame.
    assign cap_active   = capturing_q || start_accept;
    assign beat         = pixel_valid && cap_active;
    assign push         = beat && !fifo_full;

    always_comb begin
        capturing_d  = capturing_q;
        cap_cnt_d    = cap_cnt_q;
        drop_frame_d = drop_frame_q;
        if (start_accept) begin
            capturing_d  = 1'b1;
            cap_cnt_d    = '0;
            drop_frame_d = 1'b0;
        end
        if (beat) begin
            if (cap_cnt_d == LastIdx) begin
                capturing_d = 1'b0;
            end
            cap_cnt_d = cap_cnt_d + 16'd1;
            if (fifo_full) begin
                drop_frame_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = tx_data_q;
        valid_d   = tx_valid_q;
        hold_d    = hold_q;
        pix_cnt_d = pix_cnt_q;
        fcnt_d    = fcnt_q;
        csum_d    = csum_q;
        load_pix  = 1'b0;
        pop       = 1'b0;

        if (xfer && (state_q >= StFcnt) && (state_q <= StStatus)) begin
            csum_d = csum_q + tx_data_q;
        end

        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d   = StHdr0;
                    data_d    = 8'hAA;
                    valid_d   = 1'b1;
                    csum_d    = '0;
                    pix_cnt_d = '0;
                end
            end
            StHdr0: if (xfer) begin state_d = StHdr1; data_d = 8'h55;     end
            StHdr1: if (xfer) begin state_d = StFcnt; data_d = fcnt_q;    end
            StFcnt: if (xfer) begin state_d = StLenH; data_d = Len[15:8]; end
            StLenH: if (xfer) begin state_d = StLenL; data_d = Len[7:0];  end
            StLenL: begin
                if (xfer) begin
                    state_d  = StPixH;
                    load_pix = 1'b1;
                end
            end
            StPixH: begin
                if (xfer) begin
                    state_d = StPixL;
                    data_d  = hold_q[7:0];
                end else if (!tx_valid_q) begin
                    load_pix = 1'b1;
                end
            end
            StPixL: begin
                if (xfer) begin
                    pix_cnt_d = pix_cnt_q + 16'd1;
                    if (pix_cnt_q == LastIdx) begin
                        state_d = StStatus;
                        data_d  = {7'd0, drop_frame_q};
                    end else begin
                        state_d  = StPixH;
                        load_pix = 1'b1;
                    end
                end
            end
            StStatus: if (xfer) begin state_d = StCsum; data_d = csum_d; end
            StCsum: begin
                if (xfer) begin
                    state_d = StIdle;
                    data_d  = '0;
                    valid_d = 1'b0;
                    fcnt_d  = fcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase

        // Empty FIFO: wait while capture runs, otherwise pad with zero words.
        if (load_pix) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                hold_d  = fifo_mem[rd_ptr_q];
                data_d  = fifo_mem[rd_ptr_q][15:8];
                valid_d = 1'b1;
            end else if (capturing_q) begin
                valid_d = 1'b0;
            end else begin
                hold_d  = '0;
                data_d  = '0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= pixel_data;
        end
    end

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            hold_q       <= '0;
            pix_cnt_q    <= '0;
            fcnt_q       <= '0;
            csum_q       <= '0;
            capturing_q  <= 1'b0;
            cap_cnt_q    <= '0;
            drop_frame_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= data_d;
            tx_valid_q   <= valid_d;
            hold_q       <= hold_d;
            pix_cnt_q    <= pix_cnt_d;
            fcnt_q       <= fcnt_d;
            csum_q       <= csum_d;
            capturing_q  <= capturing_d;
            cap_cnt_q    <= cap_cnt_d;
            drop_frame_q <= drop_frame_d;
            overflow_q   <= overflow_q | (beat && fifo_full);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign busy          = (state_q != StIdle);
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_spectrum_frame_packer.sv
// Bench for spectrum_frame_packer: one instance with a deep FIFO for framing,
// backpressure, ignored starts, reset and counter wrap; one with a 2-word FIFO for overflow.
module tb_spectrum_frame_packer;

    typedef struct {
        logic [15:0] w0, w1, w2, w3;
        bit          rnd;
        bit          same;
        logic [7:0]  fcnt;
        logic [7:0]  status;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fs_a = 1'b0, fs_b = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [15:0] pixel_data = '0;
    logic        ready_a = 1'b1, ready_b = 1'b1;
    bit          rmode_a = 1'b0;
    logic [7:0]  data_a, data_b;
    logic        valid_a, valid_b, busy_a, busy_b, ovf_a, ovf_b;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [7:0]  exp_byte;
    logic        pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0;
    logic [7:0]  pd_a = '0, pd_b = '0;
    bit          last_a = 1'b0, last_b = 1'b0;
    vec_t        vecs [4];

    always #10 clk = ~clk;

    spectrum_frame_packer #(.PIXELS(4), .FIFO_DEPTH(16)) dut_a (
        .clk_50m(clk), .rst(rst), .frame_start(fs_a), .pixel_valid(pixel_valid),
        .pixel_data(pixel_data), .tx_data(data_a), .tx_data_valid(valid_a),
        .tx_data_ready(ready_a), .busy(busy_a), .overflow(ovf_a)
    );

    spectrum_frame_packer #(.PIXELS(4), .FIFO_DEPTH(2)) dut_b (
        .clk_50m(clk), .rst(rst), .frame_start(fs_b), .pixel_valid(pixel_valid),
        .pixel_data(pixel_data), .tx_data(data_b), .tx_data_valid(valid_b),
        .tx_data_ready(ready_b), .busy(busy_b), .overflow(ovf_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input bit which, input logic [7:0] fc, input logic [15:0] w0,
                            input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3, input logic [7:0] st);
        logic [7:0] b [15];
        logic [7:0] sum;
        b = '{8'hAA, 8'h55, fc, 8'h00, 8'h04, w0[15:8], w0[7:0], w1[15:8], w1[7:0],
              w2[15:8], w2[7:0], w3[15:8], w3[7:0], st, 8'h00};
        sum = '0;
        for (int i = 2; i < 14; i++) sum = sum + b[i];
        b[14] = sum;
        for (int i = 0; i < 15; i++) begin
            if (which) qb.push_back(b[i]);
            else qa.push_back(b[i]);
        end
    endtask

    task automatic wait_idle(input bit which);
        int n;
        n = 0;
        while ((which ? busy_b : busy_a) && n < 400) begin
            tick;
            n++;
        end
        if (which ? busy_b : busy_a) begin
            checks++;
            errors++;
            $display("FAIL timeout_%0d actual busy required idle", which);
        end
        check(which ? "drain_b" : "drain_a", which ? qb.size() : qa.size(), 0);
    endtask

    task automatic frame_a(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3, input bit same, input bit extra,
                           input logic [7:0] fc);
        logic [15:0] w [4];
        w = '{w0, w1, w2, w3};
        push_pkt(1'b0, fc, w0, w1, w2, w3, 8'h00);
        fs_a = 1'b1;
        if (same) begin
            pixel_valid = 1'b1;
            pixel_data  = w0;
        end
        tick;
        fs_a        = 1'b0;
        pixel_valid = 1'b0;
        check("lat_valid_a", 32'(valid_a), 1);
        check("lat_data_a", 32'(data_a), 32'hAA);
        check("busy_rise_a", 32'(busy_a), 1);
        for (int i = (same ? 1 : 0); i < 4; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = w[i];
            tick;
        end
        pixel_valid = 1'b0;
        if (extra) begin
            tick;
            tick;
            fs_a        = 1'b1;
            pixel_valid = 1'b1;
            pixel_data  = 16'hFFFF;
            tick;
            fs_a        = 1'b0;
            pixel_valid = 1'b0;
            check("extra_start_busy_a", 32'(busy_a), 1);
        end
        wait_idle(1'b0);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        ready_a = rmode_a ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            pv_a = 1'b0; last_a = 1'b0;
            pv_b = 1'b0; last_b = 1'b0;
        end else begin
            if (last_a) begin check("busy_fall_a", 32'(busy_a), 0); last_a = 1'b0; end
            if (pv_a && !pr_a) check("hold_a", {23'd0, valid_a, data_a}, {23'd0, 1'b1, pd_a});
            if (valid_a && ready_a) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_byte_a actual %h required none", data_a);
                end else begin
                    exp_byte = qa.pop_front();
                    check("byte_a", 32'(data_a), 32'(exp_byte));
                    if (qa.size() == 0) begin check("busy_hold_a", 32'(busy_a), 1); last_a = 1'b1; end
                end
            end
            pv_a = valid_a; pr_a = ready_a; pd_a = data_a;

            if (last_b) begin check("busy_fall_b", 32'(busy_b), 0); last_b = 1'b0; end
            if (pv_b && !pr_b) check("hold_b", {23'd0, valid_b, data_b}, {23'd0, 1'b1, pd_b});
            if (valid_b && ready_b) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_byte_b actual %h required none", data_b);
                end else begin
                    exp_byte = qb.pop_front();
                    check("byte_b", 32'(data_b), 32'(exp_byte));
                    if (qb.size() == 0) begin check("busy_hold_b", 32'(busy_b), 1); last_b = 1'b1; end
                end
            end
            pv_b = valid_b; pr_b = ready_b; pd_b = data_b;
        end
    end

    initial begin
        vecs[0] = '{w0: 16'h1234, w1: 16'h5678, w2: 16'h9ABC, w3: 16'hDEF0,
                    rnd: 1'b0, same: 1'b0, fcnt: 8'd0, status: 8'h00};
        vecs[1] = '{w0: 16'h1234, w1: 16'h5678, w2: 16'h9ABC, w3: 16'hDEF0,
                    rnd: 1'b1, same: 1'b0, fcnt: 8'd1, status: 8'h00};
        vecs[2] = '{w0: 16'hFFFF, w1: 16'h0000, w2: 16'h8001, w3: 16'h7FFE,
                    rnd: 1'b1, same: 1'b1, fcnt: 8'd2, status: 8'h00};
        vecs[3] = '{w0: 16'h00FF, w1: 16'hFF00, w2: 16'hA5A5, w3: 16'h5A5A,
                    rnd: 1'b0, same: 1'b1, fcnt: 8'd3, status: 8'h00};

        #25;
        check("rst_data_a", 32'(data_a), 0);
        check("rst_valid_a", 32'(valid_a), 0);
        check("rst_busy_a", 32'(busy_a), 0);
        check("rst_ovf_a", 32'(ovf_a), 0);
        check("rst_data_b", 32'(data_b), 0);
        check("rst_valid_b", 32'(valid_b), 0);
        check("rst_busy_b", 32'(busy_b), 0);
        check("rst_ovf_b", 32'(ovf_b), 0);
        rst = 1'b1;
        tick;
        tick;

        for (int i = 0; i < 4; i++) begin
            rmode_a = vecs[i].rnd;
            frame_a(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3, vecs[i].same, 1'b0,
                    vecs[i].fcnt);
            rmode_a = 1'b0;
            tick;
            check("status_ovf_a", 32'(ovf_a), 32'(vecs[i].status));
        end

        // Start pulse (with a stray pixel) in the middle of the payload is ignored.
        frame_a(16'h0102, 16'h0304, 16'h0506, 16'h0708, 1'b0, 1'b1, 8'd4);
        frame_a(16'hCAFE, 16'hBEEF, 16'h1357, 16'h2468, 1'b0, 1'b0, 8'd5);

        // Overflow: 2-word FIFO, sink stalled while all four pixels arrive.
        ready_b = 1'b0;
        fs_b    = 1'b1;
        tick;
        fs_b    = 1'b0;
        check("lat_data_b", 32'(data_b), 32'hAA);
        for (int i = 0; i < 4; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = 16'h1111 * 16'(i + 1);
            tick;
        end
        pixel_valid = 1'b0;
        check("ovf_b", 32'(ovf_b), 1);
        check("ovf_a_clear", 32'(ovf_a), 0);
        push_pkt(1'b1, 8'd0, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 8'h01);
        ready_b = 1'b1;
        wait_idle(1'b1);
        check("ovf_b_sticky", 32'(ovf_b), 1);

        // Reset while LEN_L is on the bus.
        push_pkt(1'b0, 8'd6, 16'h0, 16'h0, 16'h0, 16'h0, 8'h00);
        fs_a = 1'b1;
        tick;
        fs_a = 1'b0;
        tick; tick; tick; tick;
        check("at_lenl_a", 32'(data_a), 32'h04);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid_a", 32'(valid_a), 0);
        check("arst_data_a", 32'(data_a), 0);
        check("arst_busy_a", 32'(busy_a), 0);
        check("arst_ovf_b", 32'(ovf_b), 0);
        qa.delete();
        #1;
        rst = 1'b1;
        tick;

        // 257 back-to-back frames after reset: FCNT 0..255 then 0.
        for (int f = 0; f < 257; f++) begin
            frame_a(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    f[0], 1'b0, f[7:0]);
        end
        check("final_ovf_a", 32'(ovf_a), 0);

        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
